// File: rtl/router_pkt_src.sv
// router_pkt_src: LFSR packet generator that drives the router input port under busy back-pressure
module router_pkt_src #(
  parameter int MAX_LEN = 63
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [1:0]                       dest,
  input  logic [$clog2(MAX_LEN+1)-1:0]     len,
  input  logic [7:0]                       seed,
  input  logic                             inject_err,
  input  logic                             busy,
  output logic                             pkt_valid,
  output logic [7:0]                       data_in,
  output logic                             active,
  output logic                             done,
  output logic [15:0]                      pkt_count
);
  localparam int LW = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;
  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d, par_q, par_d, data_q, data_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, valid_q, valid_d, active_q, active_d, done_q, done_d;
  logic [15:0]   count_q, count_d;
  logic [7:0]    lfsr_nx;
  assign lfsr_nx   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign pkt_valid = valid_q;
  assign data_in   = data_q;
  assign active    = active_q;
  assign done      = done_q;
  assign pkt_count = count_q;
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    par_d    = par_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    valid_d  = valid_q;
    active_d = active_q;
    done_d   = 1'b0;
    count_d  = count_q;
    case (state_q)
      IDLE:
        if (start && len != '0 && dest != 2'b11) begin
          state_d  = HEADER;
          lfsr_d   = seed == 8'h00 ? 8'h01 : seed;
          err_d    = inject_err;
          cnt_d    = len;
          par_d    = {len, dest};
          data_d   = {len, dest};
          valid_d  = 1'b1;
          active_d = 1'b1;
        end
      HEADER:
        if (!busy) begin
          state_d = PAYLOAD;
          data_d  = lfsr_q;
        end
      PAYLOAD:
        if (!busy) begin
          par_d  = par_q ^ data_q;
          lfsr_d = lfsr_nx;
          cnt_d  = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = PARITY;
            valid_d = 1'b0;
            data_d  = par_q ^ data_q ^ {7'b0, err_q};
          end else begin
            data_d = lfsr_nx;
          end
        end
      PARITY:
        if (!busy) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          count_d  = count_q + 16'd1;
          active_d = 1'b0;
          data_d   = 8'h00;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      lfsr_q   <= 8'h01;
      par_q    <= 8'h00;
      data_q   <= 8'h00;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      par_q    <= par_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end
endmodule
